// File: rtl/shift_unit.sv
// shift_unit: iterative shift/rotate engine moving at most STEP bits per clock.
// Rotates (op 011/100) are built only when SHIFT_UNIT_ROTATE_EN is defined; otherwise they are illegal.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);
    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;
    localparam int KW = $clog2(STEP) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [2:0] opr;
    logic sign, ill_q, ill_c, accept, rot, right;
    logic [CW-1:0] rem, rem_nx, n;
    logic [KW-1:0] k;
    logic [2*WIDTH-1:0] dr, dl;
    always_comb begin
        accept = start && state != SHIFT;
`ifdef SHIFT_UNIT_ROTATE_EN
        ill_c = op > 3'd4;
        rot = opr == 3'd3 || opr == 3'd4;
`else
        ill_c = op > 3'd2;
        rot = 1'b0;
`endif
        // Saturate plain shifts at WIDTH; rotates only need the amount modulo WIDTH.
        n = ill_c ? '0 : (|b[WIDTH-1:LW] && op < 3'd3) ? CW'(WIDTH) : {1'b0, b[LW-1:0]};
        k = rem > CW'(STEP) ? KW'(STEP) : KW'(rem);
        right = opr != 3'd2 && opr != 3'd4;
        dr = {opr == 3'd1 ? {WIDTH{sign}} : rot ? work : '0, work} >> k;
        dl = {work, rot ? work : '0} << k;
        work_nx = right ? dr[WIDTH-1:0] : dl[2*WIDTH-1:WIDTH];
        rem_nx = rem - CW'(k);
        state_nx = accept ? (|n ? SHIFT : DONE) : state == SHIFT ? (|rem_nx ? SHIFT : DONE) : IDLE;
        busy = state == SHIFT;
        done = state == DONE;
        result = work;
        illegal = ill_q;
    end
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            work <= '0;
            opr <= '0;
            sign <= 1'b0;
            rem <= '0;
            ill_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                work <= a;
                opr <= op;
                sign <= a[WIDTH-1];
                rem <= n;
                ill_q <= ill_c;
            end else if (state == SHIFT) begin
                work <= work_nx;
                rem <= rem_nx;
            end
        end
    end
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: directed checks of shift_unit (WIDTH=32, STEP=4), both rotate build options.
module tb_shift_unit;
    logic clock = 1'b0, clear_n = 1'b0, start = 1'b0;
    logic [2:0] op = '0;
    logic [31:0] a = '0, b = '0, result;
    logic busy, done, illegal;
    int vectors = 0, miscompares = 0;

    shift_unit #(.WIDTH(32), .STEP(4)) dut (
        .clock(clock), .clear_n(clear_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .illegal(illegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request and let the next edge accept it; returns in cycle k+1.
    task automatic launch(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0; a = 32'hxxxx_xxxx; b = 32'hxxxx_xxxx; op = 3'bxxx;
    endtask

    // Expect nb busy cycles then the done cycle; returns while still in the done cycle.
    task automatic expect_done(input string tag, input int nb, input logic [31:0] res, input logic ill);
        for (int i = 0; i < nb; i++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " no done while busy"}, {31'd0, done}, 32'd0);
            tick();
        end
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " busy off at done"}, {31'd0, busy}, 32'd0);
        chk({tag, " result"}, result, res);
        chk({tag, " illegal"}, {31'd0, illegal}, {31'd0, ill});
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, " idle busy"}, {31'd0, busy}, 32'd0);
        chk({tag, " idle done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        clear_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("reset result", result, 32'd0);
            chk("reset busy", {31'd0, busy}, 32'd0);
            chk("reset done", {31'd0, done}, 32'd0);
            chk("reset illegal", {31'd0, illegal}, 32'd0);
            tick();
        end

        launch(3'd1, 32'h8000_0000, 32'd4);
        expect_done("shra4", 1, 32'hF800_0000, 1'b0);
        tick();
        expect_idle("after shra4");

        launch(3'd0, 32'hFFFF_FFFF, 32'd40);
        expect_done("shr40", 8, 32'h0000_0000, 1'b0);
        tick();

        launch(3'd2, 32'h0000_FFFF, 32'd16);
        expect_done("shl16", 4, 32'hFFFF_0000, 1'b0);
        tick();

        launch(3'd1, 32'h8000_0000, 32'd100);
        expect_done("shra100", 8, 32'hFFFF_FFFF, 1'b0);
        tick();

        launch(3'd1, 32'h7FFF_FFFF, 32'd31);
        expect_done("shra31", 8, 32'h0000_0000, 1'b0);
        tick();

        launch(3'd7, 32'hDEAD_BEEF, 32'd5);
        expect_done("op7", 0, 32'hDEAD_BEEF, 1'b1);
        tick();

        launch(3'd0, 32'hFFFF_FFFF, 32'd5);
        expect_done("shr5", 2, 32'h07FF_FFFF, 1'b0);
        tick();

`ifdef SHIFT_UNIT_ROTATE_EN
        launch(3'd4, 32'h8000_0001, 32'd33);
        expect_done("rol33", 1, 32'h0000_0003, 1'b0);
`else
        launch(3'd4, 32'h8000_0001, 32'd33);
        expect_done("rol33 off", 0, 32'h8000_0001, 1'b1);
`endif
        tick();

        launch(3'd0, 32'h1234_5678, 32'd0);
        expect_done("b0", 0, 32'h1234_5678, 1'b0);
        launch(3'd2, 32'h0000_00A5, 32'd0);
        expect_done("b2b b0", 0, 32'h0000_00A5, 1'b0);
`ifdef SHIFT_UNIT_ROTATE_EN
        launch(3'd3, 32'h1234_5678, 32'd8);
        expect_done("b2b ror8", 2, 32'h7812_3456, 1'b0);
`else
        launch(3'd3, 32'h1234_5678, 32'd8);
        expect_done("b2b ror8 off", 0, 32'h1234_5678, 1'b1);
`endif
        tick();
        expect_idle("after b2b");
        chk("result holds", result, `ifdef SHIFT_UNIT_ROTATE_EN 32'h7812_3456 `else 32'h1234_5678 `endif);

        launch(3'd2, 32'h0000_0001, 32'd20);
        chk("abort busy k+1", {31'd0, busy}, 32'd1);
        tick();
        op = 3'd0; a = 32'h55; b = 32'd0; start = 1'b1;
        chk("abort busy k+2", {31'd0, busy}, 32'd1);
        tick();
        start = 1'b0;
        chk("start ignored busy", {31'd0, busy}, 32'd1);
        chk("start ignored done", {31'd0, done}, 32'd0);
        clear_n = 1'b0;
        #1;
        chk("abort result", result, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort illegal", {31'd0, illegal}, 32'd0);
        tick();
        clear_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_idle("post abort");
            chk("post abort result", result, 32'd0);
            tick();
        end

        launch(3'd0, 32'h0000_0100, 32'd8);
        expect_done("shr8 fresh", 2, 32'h0000_0001, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
